conv2d_window_gen: RTL and testbench
====================================

# conv2d_window_gen

Upstream feeder for the conv2d accelerator. Accepts a raster-order pixel stream under a valid/ready handshake and buffers the two previous image rows in line buffers. Emits every fully-populated 3x3 image patch (valid convolution, no padding) as a registered 2D array shaped exactly like the accelerator's `image_patch` input. Emits at most one patch per cycle, with backpressure.

## Interface
- `DATA_WIDTH`, 8, pixel width (package value).
- `FILTER_SIZE`, 3, window edge; only 3 is supported.
- `IMG_WIDTH`, 8, pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, 8, rows per frame; must be ≥ 3.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pix_valid` input 1: `pix_data` is valid.
- `pix_ready` output 1: block can accept a pixel.
- `pix_data` input `DATA_WIDTH`: pixel, raster order, row 0 col 0 first.
- `patch_valid` output 1: `image_patch` holds a valid window.
- `patch_ready` input 1: downstream accepts the patch.
- `image_patch` output [FILTER_SIZE-1:0][FILTER_SIZE-1:0] x `DATA_WIDTH`: `[i][j]` = row i, col j of the window; `[0][0]` is top-left (oldest), `[2][2]` is the newest pixel.
- `patch_row` output `$clog2(IMG_HEIGHT)`: image row of the window's top-left pixel.
- `patch_col` output `$clog2(IMG_WIDTH)`: image column of the window's top-left pixel.
- `patch_last` output 1: this patch is the last of the frame.

## Operation
- Pixel accept = `pix_valid && pix_ready`. Patch accept = `patch_valid && patch_ready`.
- `pix_ready = !patch_valid || patch_ready`. This is a one-deep output register with pass-through when drained.
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance only on pixel accept.
  - `col` wraps to 0 and increments `row`.
  - At row=H-1, col=W-1 both wrap to 0; the next pixel starts a new frame. There is no frame-start input.
- Two line buffers, `lb1` (previous row) and `lb0` (row before that), each IMG_WIDTH entries and indexed by `col`. On each pixel accept:
  - The window shift register (3x3) shifts left by one column.
  - New right column = {`lb0[col]`, `lb1[col]`, `pix_data`} (top to bottom).
  - `lb0[col] <= lb1[col]`; `lb1[col] <= pix_data`.
- Patch load: on a pixel accept with row ≥ 2 and col ≥ 2, the following are registered:
  - `image_patch` ← the post-shift window.
  - `patch_row` ← row-2; `patch_col` ← col-2.
  - `patch_last` ← (row==H-1 && col==W-1).
  - `patch_valid` ← 1.
- Otherwise, a patch accept clears `patch_valid`. With no accept, the outputs hold stable.
- Patches per frame: (IMG_HEIGHT-2)·(IMG_WIDTH-2), in raster order.
- Line buffers and the window are not reset. Stale contents are never emitted, because the row ≥ 2 / col ≥ 2 gating guarantees every window element was written in the current frame.
- There is no arithmetic. Data passes through bit-exact.

## Timing
- Reset values:
  - `patch_valid` 0, `patch_last` 0.
  - `image_patch` all 0, `patch_row` 0, `patch_col` 0.
  - `row` 0, `col` 0.
  - `pix_ready` 1 (combinational, follows from `patch_valid` = 0).
- Latency: a patch becomes visible one cycle after the edge that accepts its bottom-right pixel.
- Throughput: one pixel and one patch per cycle when `patch_ready` is held high.
- Stall: while `patch_valid && !patch_ready`:
  - `pix_ready` = 0.
  - Window, counters, line buffers and outputs are frozen.
  - `pix_data` is ignored.
- Simultaneous patch accept and pixel accept that loads a new patch: `patch_valid` stays 1 and the outputs update to the new patch. There is no bubble.
- Simultaneous patch accept and pixel accept that does not load (col < 2 or row < 2): `patch_valid` → 0.
- `pix_valid` gaps: no state changes. Output patches are spaced accordingly.
- `rst` low mid-frame: outputs clear immediately (asynchronous). After release, the next accepted pixel is treated as row 0, col 0, and no patch from the aborted frame is emitted.

## Test plan
- W=H=5, pixel = 5·row+col, `patch_ready`=1. Expect:
  - 9 patches.
  - First patch one cycle after pixel 12 is accepted, equal to {0,1,2; 5,6,7; 10,11,12}, with (row,col)=(0,0).
  - Last patch {12,13,14; 17,18,19; 22,23,24}, with `patch_last`=1 and (2,2).
- Same frame with `patch_ready` toggling at random. Expect an identical patch sequence, no drops or duplicates, `pix_ready`=0 exactly while a patch is stalled, and outputs stable during stalls.
- Random `pix_valid` gaps, W=8, H=4. Expect 12 patches matching a reference model of the sliding window.
- Two back-to-back frames with different data. Expect the second frame's first patch to contain only second-frame pixels, and `patch_last` once per frame.
- Drive `rst`=0 after 7 pixels of a 5x5 frame, release, then send a full frame. Expect `patch_valid`=0 during reset, and exactly 9 patches, all from the new frame.
- Minimum size W=H=3. Expect a single patch equal to the whole frame, with `patch_last`=1.

Source files
------------

// File: rtl/conv2d_window_gen.sv
// conv2d_window_gen: turns a raster-order pixel stream into the 3x3 patches of a
// valid (unpadded) convolution. Two line buffers hold the previous two rows; a
// one-deep output register presents each patch under valid/ready handshaking.
module conv2d_window_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int FILTER_SIZE = 3,   // only 3 is supported
    parameter int IMG_WIDTH   = 8,   // >= 3
    parameter int IMG_HEIGHT  = 8    // >= 3
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   pix_valid,
    output logic                                                   pix_ready,
    input  logic [DATA_WIDTH-1:0]                                  pix_data,
    output logic                                                   patch_valid,
    input  logic                                                   patch_ready,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] image_patch,
    output logic [$clog2(IMG_HEIGHT)-1:0]                          patch_row,
    output logic [$clog2(IMG_WIDTH)-1:0]                           patch_col,
    output logic                                                   patch_last
);

    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    typedef logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] window_t;

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];   // row before the previous one
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];   // previous row
    window_t               win;
    window_t               win_next;

    logic pix_acc;
    logic patch_acc;
    logic col_end;
    logic row_end;
    logic load;

    // Output register drains or passes through, so a pixel is taken whenever
    // the held patch is absent or leaving this cycle.
    assign pix_ready = !patch_valid || patch_ready;
    assign pix_acc   = pix_valid && pix_ready;
    assign patch_acc = patch_valid && patch_ready;
    assign col_end   = (col == COL_W'(IMG_WIDTH - 1));
    assign row_end   = (row == ROW_W'(IMG_HEIGHT - 1));
    // Row/col >= 2 guarantees every window element belongs to the current frame.
    assign load      = pix_acc && (row >= ROW_W'(2)) && (col >= COL_W'(2));

    // Window after shifting left one column and inserting the new right column.
    always_comb begin
        win_next    = win;
        win_next[0] = {lb0[col], win[0][2], win[0][1]};
        win_next[1] = {lb1[col], win[1][2], win[1][1]};
        win_next[2] = {pix_data, win[2][2], win[2][1]};
    end

    // Line buffers and window shift register (data path, not reset).
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb0[col] <= lb1[col];
            lb1[col] <= pix_data;
            win      <= win_next;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_acc) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Output patch register: a new load takes priority over a drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            patch_valid <= 1'b0;
            patch_last  <= 1'b0;
            image_patch <= '0;
            patch_row   <= '0;
            patch_col   <= '0;
        end else if (load) begin
            patch_valid <= 1'b1;
            patch_last  <= row_end && col_end;
            image_patch <= win_next;
            patch_row   <= row - ROW_W'(2);
            patch_col   <= col - COL_W'(2);
        end else if (patch_acc) begin
            patch_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv2d_window_gen.sv
// Self-checking bench for conv2d_window_gen: three instances (5x5, 8x4, 3x3)
// driven with randomized handshakes and compared with a sliding-window model.
module tb_conv2d_window_gen;

    typedef struct packed {
        logic                       v;
        logic                       last;
        logic [7:0]                 row;
        logic [7:0]                 col;
        logic [2:0][2:0][7:0]       patch;
    } snap_t;

    logic clk;
    logic rst;

    logic pv0, pr0, prdy0, ptv0, last0;
    logic [7:0] pd0;
    logic [2:0][2:0][7:0] ip0;
    logic [2:0] row0;
    logic [2:0] col0;

    logic pv1, pr1, prdy1, ptv1, last1;
    logic [7:0] pd1;
    logic [2:0][2:0][7:0] ip1;
    logic [1:0] row1;
    logic [2:0] col1;

    logic pv2, pr2, prdy2, ptv2, last2;
    logic [7:0] pd2;
    logic [2:0][2:0][7:0] ip2;
    logic [1:0] row2;
    logic [1:0] col2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pix_q [$];
    snap_t      got_q [$];
    snap_t      exp_q [$];
    int         acc_cyc [$];
    int         first_pv_cyc;
    int         stall_bad;
    int         ready_bad;

    conv2d_window_gen #(.DATA_WIDTH(8), .FILTER_SIZE(3), .IMG_WIDTH(5), .IMG_HEIGHT(5)) u_5x5 (
        .clk(clk), .rst(rst), .pix_valid(pv0), .pix_ready(prdy0), .pix_data(pd0),
        .patch_valid(ptv0), .patch_ready(pr0), .image_patch(ip0),
        .patch_row(row0), .patch_col(col0), .patch_last(last0)
    );

    conv2d_window_gen #(.DATA_WIDTH(8), .FILTER_SIZE(3), .IMG_WIDTH(8), .IMG_HEIGHT(4)) u_8x4 (
        .clk(clk), .rst(rst), .pix_valid(pv1), .pix_ready(prdy1), .pix_data(pd1),
        .patch_valid(ptv1), .patch_ready(pr1), .image_patch(ip1),
        .patch_row(row1), .patch_col(col1), .patch_last(last1)
    );

    conv2d_window_gen #(.DATA_WIDTH(8), .FILTER_SIZE(3), .IMG_WIDTH(3), .IMG_HEIGHT(3)) u_3x3 (
        .clk(clk), .rst(rst), .pix_valid(pv2), .pix_ready(prdy2), .pix_data(pd2),
        .patch_valid(ptv2), .patch_ready(pr2), .image_patch(ip2),
        .patch_row(row2), .patch_col(col2), .patch_last(last2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    function automatic snap_t get_snap(input int k);
        snap_t s;
        s = '0;
        case (k)
            0: begin s.v = ptv0; s.last = last0; s.row = 8'(row0); s.col = 8'(col0); s.patch = ip0; end
            1: begin s.v = ptv1; s.last = last1; s.row = 8'(row1); s.col = 8'(col1); s.patch = ip1; end
            2: begin s.v = ptv2; s.last = last2; s.row = 8'(row2); s.col = 8'(col2); s.patch = ip2; end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic get_prdy(input int k);
        case (k)
            0: return prdy0;
            1: return prdy1;
            2: return prdy2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_in(input int k, input logic v, input logic [7:0] d, input logic r);
        case (k)
            0: begin pv0 = v; pd0 = d; pr0 = r; end
            1: begin pv1 = v; pd1 = d; pr1 = r; end
            2: begin pv2 = v; pd2 = d; pr2 = r; end
            default: ;
        endcase
    endtask

    // Reference: every 3x3 sub-block of each W x H frame in pix_q, raster order.
    task automatic build_expected(input int w, input int h);
        snap_t s;
        int frames;
        int base;
        exp_q.delete();
        frames = pix_q.size() / (w * h);
        for (int f = 0; f < frames; f++) begin
            base = f * w * h;
            for (int r = 0; r < h - 2; r++) begin
                for (int c = 0; c < w - 2; c++) begin
                    s = '0;
                    s.v    = 1'b1;
                    s.last = (r == h - 3) && (c == w - 3);
                    s.row  = 8'(r);
                    s.col  = 8'(c);
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            s.patch[2'(i)][2'(j)] = pix_q[base + (r + i) * w + c + j];
                    exp_q.push_back(s);
                end
            end
        end
    endtask

    // Streams pix_q into instance k and records every accepted patch.
    // vmode: 0 = pix_valid always, 1 = random gaps. rmode: 0 = ready, 1 = random, 2 = never.
    task automatic run_stream(input int k, input int vmode, input int rmode,
                              input bit drain, input int budget);
        int idx;
        int cyc;
        snap_t s;
        snap_t prev;
        bit prev_stall;
        logic v;
        logic r;
        logic rdy;
        logic [7:0] d;
        idx = 0;
        cyc = 0;
        prev = '0;
        prev_stall = 1'b0;
        got_q.delete();
        acc_cyc.delete();
        first_pv_cyc = -1;
        stall_bad = 0;
        ready_bad = 0;
        forever begin
            @(negedge clk);
            s = get_snap(k);
            if (idx >= pix_q.size() && (!drain || !s.v)) break;
            if (cyc >= budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_timeout: got %0d of %0d pixels taken, patch_valid=%0b after %0d cycles, required completion",
                         idx, pix_q.size(), s.v, cyc);
                break;
            end
            v = (idx < pix_q.size()) && (vmode == 0 || $urandom_range(0, 2) != 0);
            d = v ? pix_q[idx] : 8'($urandom);
            r = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            set_in(k, v, d, r);
            #1;
            s   = get_snap(k);
            rdy = get_prdy(k);
            if (s.v && first_pv_cyc < 0) first_pv_cyc = cyc;
            if (prev_stall && s !== prev) stall_bad++;
            if (rdy !== (!s.v || r)) ready_bad++;
            if (s.v && r) got_q.push_back(s);
            if (v && rdy) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            prev = s;
            prev_stall = s.v && !r;
            cyc++;
        end
        set_in(k, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset;
        snap_t s;
        rst = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        set_in(2, 1'b0, 8'h00, 1'b0);
        #12;
        for (int k = 0; k < 3; k++) begin
            s = get_snap(k);
            n_cmp++;
            if (s !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got %h required 0", k, s);
            end
            n_cmp++;
            if (get_prdy(k) !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_pix_ready[%0d]: got %b required 1", k, get_prdy(k));
            end
        end
        #10;
        rst = 1'b1;
    endtask

    task automatic test_basic;
        logic [2:0][2:0][7:0] c_first;
        logic [2:0][2:0][7:0] c_last;
        pix_q.delete();
        for (int i = 0; i < 25; i++) pix_q.push_back(8'(i));
        build_expected(5, 5);
        run_stream(0, 0, 0, 1'b1, 200);
        n_cmp++;
        if (got_q.size() !== 9) begin
            n_bad++;
            $display("FAIL basic_count: got %0d patches required 9", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL basic_patch[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        c_first[0] = {8'd2, 8'd1, 8'd0};
        c_first[1] = {8'd7, 8'd6, 8'd5};
        c_first[2] = {8'd12, 8'd11, 8'd10};
        c_last[0]  = {8'd14, 8'd13, 8'd12};
        c_last[1]  = {8'd19, 8'd18, 8'd17};
        c_last[2]  = {8'd24, 8'd23, 8'd22};
        if (got_q.size() > 0) begin
            n_cmp++;
            if (got_q[0].patch !== c_first || got_q[0].row !== 8'd0 || got_q[0].col !== 8'd0) begin
                n_bad++;
                $display("FAIL basic_first: got %h required patch %h at (0,0)", got_q[0], c_first);
            end
            n_cmp++;
            if (got_q[got_q.size()-1].patch !== c_last || got_q[got_q.size()-1].last !== 1'b1 ||
                got_q[got_q.size()-1].row !== 8'd2 || got_q[got_q.size()-1].col !== 8'd2) begin
                n_bad++;
                $display("FAIL basic_last: got %h required patch %h last=1 at (2,2)",
                         got_q[got_q.size()-1], c_last);
            end
        end
        if (acc_cyc.size() > 12) begin
            n_cmp++;
            if (first_pv_cyc !== acc_cyc[12] + 1) begin
                n_bad++;
                $display("FAIL basic_latency: first patch at cycle %0d required %0d", first_pv_cyc, acc_cyc[12] + 1);
            end
        end
        n_cmp++;
        if (ready_bad !== 0) begin
            n_bad++;
            $display("FAIL basic_pix_ready: got %0d bad cycles required 0", ready_bad);
        end
    endtask

    task automatic test_backpressure;
        pix_q.delete();
        for (int i = 0; i < 25; i++) pix_q.push_back(8'(i));
        build_expected(5, 5);
        run_stream(0, 0, 1, 1'b1, 400);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL bp_count: got %0d patches required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL bp_patch[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (stall_bad !== 0) begin
            n_bad++;
            $display("FAIL bp_stall_stable: got %0d changed stall cycles required 0", stall_bad);
        end
        n_cmp++;
        if (ready_bad !== 0) begin
            n_bad++;
            $display("FAIL bp_pix_ready: got %0d bad cycles required 0", ready_bad);
        end
    endtask

    task automatic test_valid_gaps;
        pix_q.delete();
        for (int i = 0; i < 32; i++) pix_q.push_back(8'($urandom));
        build_expected(8, 4);
        run_stream(1, 1, 1, 1'b1, 600);
        n_cmp++;
        if (got_q.size() !== 12) begin
            n_bad++;
            $display("FAIL gaps_count: got %0d patches required 12", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL gaps_patch[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (stall_bad !== 0 || ready_bad !== 0) begin
            n_bad++;
            $display("FAIL gaps_handshake: got stall=%0d ready=%0d bad cycles required 0/0", stall_bad, ready_bad);
        end
    endtask

    task automatic test_back_to_back;
        int n_last;
        pix_q.delete();
        for (int i = 0; i < 50; i++) pix_q.push_back(8'($urandom));
        build_expected(5, 5);
        run_stream(0, 0, 1, 1'b1, 800);
        n_cmp++;
        if (got_q.size() !== 18) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d patches required 18", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b_patch[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        n_last = 0;
        foreach (got_q[i]) if (got_q[i].last) n_last++;
        n_cmp++;
        if (n_last !== 2) begin
            n_bad++;
            $display("FAIL b2b_last_count: got %0d required 2", n_last);
        end
    endtask

    // Aborts a 5x5 frame after 7 pixels (no patch yet) and after 13 pixels
    // (patch held by backpressure), then checks a clean full frame follows.
    task automatic test_reset_midframe;
        snap_t s;
        int nabort;
        for (int t = 0; t < 2; t++) begin
            nabort = (t == 0) ? 7 : 13;
            pix_q.delete();
            for (int i = 0; i < nabort; i++) pix_q.push_back(8'($urandom));
            run_stream(0, 0, 2, 1'b0, 100);
            s = get_snap(0);
            n_cmp++;
            if (s.v !== (nabort >= 13)) begin
                n_bad++;
                $display("FAIL abort_pre_valid[%0d]: got %b required %b", t, s.v, nabort >= 13);
            end
            #3;
            rst = 1'b0;
            #1;
            s = get_snap(0);
            n_cmp++;
            if (s !== '0 || prdy0 !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_async_clear[%0d]: got %h pix_ready=%b required 0 and 1", t, s, prdy0);
            end
            @(negedge clk);
            n_cmp++;
            if (ptv0 !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_held_valid[%0d]: got %b required 0", t, ptv0);
            end
            #2;
            rst = 1'b1;
            pix_q.delete();
            for (int i = 0; i < 25; i++) pix_q.push_back(8'($urandom));
            build_expected(5, 5);
            run_stream(0, 0, 1, 1'b1, 400);
            n_cmp++;
            if (got_q.size() !== 9) begin
                n_bad++;
                $display("FAIL abort_count[%0d]: got %0d patches required 9", t, got_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL abort_patch[%0d][%0d]: got %h required %h", t, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_min_size;
        pix_q.delete();
        for (int i = 0; i < 9; i++) pix_q.push_back(8'($urandom));
        build_expected(3, 3);
        run_stream(2, 1, 1, 1'b1, 200);
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_bad++;
            $display("FAIL min_count: got %0d patches required 1", got_q.size());
        end
        if (got_q.size() > 0) begin
            n_cmp++;
            if (got_q[0] !== exp_q[0] || got_q[0].last !== 1'b1) begin
                n_bad++;
                $display("FAIL min_patch: got %h required %h", got_q[0], exp_q[0]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_valid_gaps;
        test_back_to_back;
        test_reset_midframe;
        test_min_size;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
